// File: rtl/onehot_mask_regfile.sv
// onehot_mask_regfile: flop-based register file with one-hot addressed ports.
// One bit-masked synchronous write port and one asynchronous AND-OR read port.
// Optional simulation checks are enabled by defining ONEHOT_MASK_REGFILE_CHECK_EN.
// width_p and els_p are meant to be set by the instantiating module.
module onehot_mask_regfile #(
  parameter int unsigned width_p     = 8,
  parameter int unsigned els_p       = 4,
  localparam int unsigned safe_els_lp = (els_p == 0) ? 1 : els_p
) (
  input  logic                   w_clk_i,
  input  logic                   w_reset_n_i,
  input  logic [safe_els_lp-1:0] w_v_i,
  input  logic [width_p-1:0]     w_data_i,
  input  logic [width_p-1:0]     w_mask_i,
  input  logic [safe_els_lp-1:0] r_v_i,
  output logic [width_p-1:0]     r_data_o
);

  if (els_p == 0) begin : g_empty
    // No storage; the selects and write data are ignored.
    logic unused_inputs;
    assign unused_inputs = ^{w_clk_i, w_reset_n_i, w_v_i, w_data_i, w_mask_i, r_v_i};
    assign r_data_o      = '0;
  end else begin : g_rows
    logic [width_p-1:0] rows_q [els_p];
    logic [width_p-1:0] rows_d [els_p];

    // Next-state: merge masked write data into every selected row.
    always_comb begin
      for (int i = 0; i < int'(els_p); i++) begin
        rows_d[i] = rows_q[i];
        if (w_v_i[i]) begin
          rows_d[i] = (rows_q[i] & ~w_mask_i) | (w_data_i & w_mask_i);
        end
      end
    end

    // Row storage with asynchronous clear.
    always_ff @(posedge w_clk_i or negedge w_reset_n_i) begin
      if (!w_reset_n_i) begin
        for (int i = 0; i < int'(els_p); i++) begin
          rows_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < int'(els_p); i++) begin
          rows_q[i] <= rows_d[i];
        end
      end
    end

    // Read: AND-OR selection; multi-hot selects OR the rows together.
    always_comb begin
      r_data_o = '0;
      for (int i = 0; i < int'(els_p); i++) begin
        if (r_v_i[i]) begin
          r_data_o = r_data_o | rows_q[i];
        end
      end
    end
  end

`ifdef ONEHOT_MASK_REGFILE_CHECK_EN
  // Flag illegal multi-hot selects once per cycle, away from the write edge.
  always @(negedge w_clk_i) begin
    if (w_reset_n_i === 1'b1) begin
      if ($countones(w_v_i) > 1) begin
        $error("onehot_mask_regfile: multi-hot w_v_i = %b", w_v_i);
      end
      if ($countones(r_v_i) > 1) begin
        $error("onehot_mask_regfile: multi-hot r_v_i = %b", r_v_i);
      end
    end
  end

  // Report the size of large instances.
  initial begin
    if (width_p * els_p >= 64) begin
      $display("onehot_mask_regfile: width_p=%0d els_p=%0d", width_p, els_p);
    end
  end
`else
  // Checks compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_onehot_mask_regfile.sv
// Directed bench for onehot_mask_regfile: 8x4 main instance plus els_p=1 and els_p=0 builds.
module tb_onehot_mask_regfile;

  logic       clk;
  logic       rst_n;
  logic [3:0] w_v;
  logic [3:0] r_v;
  logic [7:0] w_data;
  logic [7:0] w_mask;
  logic [7:0] r_data;
  logic [0:0] w_v1, r_v1, w_v0, r_v0;
  logic [7:0] r_data1, r_data0;

  int checks = 0;
  int errors = 0;

  onehot_mask_regfile #(.width_p(8), .els_p(4)) u_dut (
    .w_clk_i(clk), .w_reset_n_i(rst_n), .w_v_i(w_v), .w_data_i(w_data),
    .w_mask_i(w_mask), .r_v_i(r_v), .r_data_o(r_data)
  );

  onehot_mask_regfile #(.width_p(8), .els_p(1)) u_dut1 (
    .w_clk_i(clk), .w_reset_n_i(rst_n), .w_v_i(w_v1), .w_data_i(w_data),
    .w_mask_i(w_mask), .r_v_i(r_v1), .r_data_o(r_data1)
  );

  onehot_mask_regfile #(.width_p(8), .els_p(0)) u_dut0 (
    .w_clk_i(clk), .w_reset_n_i(rst_n), .w_v_i(w_v0), .w_data_i(w_data),
    .w_mask_i(w_mask), .r_v_i(r_v0), .r_data_o(r_data0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single masked write into the 4-row instance, select dropped afterwards.
  task automatic wr(input logic [3:0] sel, input logic [7:0] data, input logic [7:0] mask);
    w_v = sel; w_data = data; w_mask = mask;
    tick();
    w_v = '0;
  endtask

  task automatic rd(input string tag, input logic [3:0] sel, input logic [7:0] exp);
    r_v = sel;
    #1;
    check(tag, r_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; w_v = '0; r_v = '0; w_data = '0; w_mask = '0;
    w_v1 = '0; r_v1 = '0; w_v0 = '0; r_v0 = '1;
    #2;
    // Reset state
    for (int i = 0; i < 4; i++) rd("reset_row", 4'(1 << i), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill all rows, then clear by asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) wr(4'(1 << i), 8'hFF, 8'hFF);
    rd("fill_row0", 4'b0001, 8'hFF);
    rd("fill_row3", 4'b1000, 8'hFF);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) rd("async_reset_row", 4'(1 << i), 8'h00);
    rd("async_reset_multi", 4'b1111, 8'h00);
    // Writes during reset are discarded
    wr(4'b0001, 8'hFF, 8'hFF);
    rd("write_in_reset", 4'b0001, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Masked writes to row 2
    wr(4'b0100, 8'hFF, 8'h0F);
    rd("mask_0f", 4'b0100, 8'h0F);
    wr(4'b0100, 8'h00, 8'h03);
    rd("mask_03", 4'b0100, 8'h0C);
    rd("mask_row0", 4'b0001, 8'h00);
    rd("mask_row1", 4'b0010, 8'h00);
    rd("mask_row3", 4'b1000, 8'h00);

    // Read during write on row 1
    wr(4'b0010, 8'hAA, 8'hFF);
    w_v = 4'b0010; w_data = 8'h55; w_mask = 8'hFF;
    rd("rdw_before", 4'b0010, 8'hAA);
    tick();
    w_v = '0;
    rd("rdw_after", 4'b0010, 8'h55);

    // Zero-hot write and empty mask are no-ops
    wr(4'b0000, 8'hFF, 8'hFF);
    rd("zerohot_w_row1", 4'b0010, 8'h55);
    rd("zerohot_w_row2", 4'b0100, 8'h0C);
    wr(4'b0100, 8'hFF, 8'h00);
    rd("empty_mask_row2", 4'b0100, 8'h0C);
    rd("zerohot_read", 4'b0000, 8'h00);

    // Multi-hot read ORs rows
    wr(4'b0001, 8'h01, 8'hFF);
    wr(4'b1000, 8'h80, 8'hFF);
    rd("multihot_read", 4'b1001, 8'h81);
    rd("multihot_read3", 4'b1110, 8'hDD);
    r_v = '0;

    // els_p=1 instance
    w_v1 = 1'b1; w_data = 8'h5A; w_mask = 8'hFF;
    tick();
    w_v1 = 1'b0;
    r_v1 = 1'b1;
    #1;
    check("els1_read", r_data1, 8'h5A);
    w_v1 = 1'b1; w_data = 8'h0F; w_mask = 8'hF0;
    tick();
    w_v1 = 1'b0;
    check("els1_mask", r_data1, 8'h0A);
    r_v1 = 1'b0;
    #1;
    check("els1_zerohot", r_data1, 8'h00);

    // els_p=0 instance always reads zero
    w_v0 = 1'b1; w_data = 8'hFF; w_mask = 8'hFF;
    tick();
    check("els0_read", r_data0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
